// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet gating and a slave-side protocol checker.
// Outputs are registered; the read head is precomputed from next-state pointers.
module axis_pkt_fifo #(
    parameter int unsigned  DATA_W      = 32,
    parameter int unsigned  DEPTH       = 16,
    parameter int unsigned  PACKET_MODE = 0,
    localparam int unsigned ADDR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              oversize,
    output logic              proto_err
);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              force_ct;

    logic              stall_q;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;

    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] wr_ptr_n;
    logic [ADDR_W-1:0] rd_ptr_n;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  pkt_n;
    logic              force_n;
    logic              valid_n;
    entry_t            head_n;
    logic              err_c;

    // Next-state view of pointers, occupancy and packet gating.
    always_comb begin
        wr       = s_tvalid && s_tready;
        rd       = m_tvalid && m_tready;
        wr_ptr_n = wr_ptr + ADDR_W'(wr);
        rd_ptr_n = rd_ptr + ADDR_W'(rd);
        count_n  = count + CNT_W'(wr) - CNT_W'(rd);
        pkt_n    = pkt_count + CNT_W'(wr && s_tlast) - CNT_W'(rd && m_tlast);

        // A full FIFO with no complete packet would deadlock; fall back to cut-through.
        force_n = force_ct;
        if (rd && m_tlast) begin
            force_n = 1'b0;
        end
        if ((PACKET_MODE != 0) && (count_n == CNT_W'(DEPTH)) && (pkt_n == '0)) begin
            force_n = 1'b1;
        end

        valid_n = (count_n != '0) && ((PACKET_MODE == 0) || (pkt_n != '0) || force_n);

        // When the beat written this edge becomes the head, storage is not yet updated.
        head_n = mem[rd_ptr_n];
        if (wr && (wr_ptr == rd_ptr_n)) begin
            head_n = '{last: s_tlast, data: s_tdata};
        end
    end

    // Slave handshake rule: a stalled beat must stay valid and unchanged.
    always_comb begin
        err_c = stall_q && (!s_tvalid || (s_tdata != prev_data) || (s_tlast != prev_last));
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= '{last: s_tlast, data: s_tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
            force_ct  <= 1'b0;
            oversize  <= 1'b0;
            proto_err <= 1'b0;
            s_tready  <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            stall_q   <= 1'b0;
            prev_data <= '0;
            prev_last <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            pkt_count <= pkt_n;
            force_ct  <= force_n;
            oversize  <= oversize || force_n;
            proto_err <= proto_err || err_c;
            s_tready  <= (count_n != CNT_W'(DEPTH));
            m_tvalid  <= valid_n;
            m_tdata   <= head_n.data;
            m_tlast   <= head_n.last;
            stall_q   <= s_tvalid && !s_tready;
            prev_data <= s_tdata;
            prev_last <= s_tlast;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: a cut-through and a packet-mode instance, both DEPTH=4,
// with per-instance scoreboard queues filled on slave handshakes and drained on master handshakes.
module tb_axis_pkt_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [DW-1:0] a_s_tdata = '0, b_s_tdata = '0;
    logic          a_s_tvalid = 1'b0, b_s_tvalid = 1'b0;
    logic          a_s_tlast = 1'b0, b_s_tlast = 1'b0;
    logic          a_s_tready, b_s_tready;
    logic [DW-1:0] a_m_tdata, b_m_tdata;
    logic          a_m_tvalid, b_m_tvalid;
    logic          a_m_tlast, b_m_tlast;
    logic          a_m_tready = 1'b0, b_m_tready = 1'b0;
    logic [CW-1:0] a_count, b_count, a_pkt_count, b_pkt_count;
    logic          a_oversize, b_oversize, a_proto_err, b_proto_err;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;
    logic [DW:0] qa[$];
    logic [DW:0] qb[$];

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DP), .PACKET_MODE(0)) u_ct (
        .clk(clk), .rst(rst),
        .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tlast(a_s_tlast), .s_tready(a_s_tready),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tready(a_m_tready),
        .count(a_count), .pkt_count(a_pkt_count), .oversize(a_oversize), .proto_err(a_proto_err)
    );

    axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DP), .PACKET_MODE(1)) u_pm (
        .clk(clk), .rst(rst),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tlast(b_s_tlast), .s_tready(b_s_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast), .m_tready(b_m_tready),
        .count(b_count), .pkt_count(b_pkt_count), .oversize(b_oversize), .proto_err(b_proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, then sample 1ns after it.
    task automatic tick();
        logic aw, ar, bw, br;
        logic [DW:0] e;
        if (rand_rdy) a_m_tready = 1'($urandom_range(0, 1));
        aw = a_s_tvalid && a_s_tready;
        ar = a_m_tvalid && a_m_tready;
        bw = b_s_tvalid && b_s_tready;
        br = b_m_tvalid && b_m_tready;
        if (ar) begin
            if (qa.size() == 0) chk("a_read_when_empty", 64'(a_m_tvalid), 64'd0);
            else begin
                e = qa.pop_front();
                chk("a_rd_beat", 64'({a_m_tlast, a_m_tdata}), 64'(e));
            end
        end
        if (br) begin
            if (qb.size() == 0) chk("b_read_when_empty", 64'(b_m_tvalid), 64'd0);
            else begin
                e = qb.pop_front();
                chk("b_rd_beat", 64'({b_m_tlast, b_m_tdata}), 64'(e));
            end
        end
        if (aw) qa.push_back({a_s_tlast, a_s_tdata});
        if (bw) qb.push_back({b_s_tlast, b_s_tdata});
        @(posedge clk);
        #1;
        chk("a_count", 64'(a_count), 64'(qa.size()));
        chk("b_count", 64'(b_count), 64'(qb.size()));
    endtask

    task automatic send_a(input logic [DW-1:0] d, input logic l);
        logic hs;
        a_s_tvalid = 1'b1; a_s_tdata = d; a_s_tlast = l;
        for (int i = 0; i < 64; i++) begin
            hs = a_s_tready;
            tick();
            if (hs) return;
        end
        chk("a_send_timeout", 64'(a_s_tready), 64'd1);
    endtask

    task automatic send_b(input logic [DW-1:0] d, input logic l);
        logic hs;
        b_s_tvalid = 1'b1; b_s_tdata = d; b_s_tlast = l;
        for (int i = 0; i < 64; i++) begin
            hs = b_s_tready;
            tick();
            if (hs) return;
        end
        chk("b_send_timeout", 64'(b_s_tready), 64'd1);
    endtask

    task automatic drain_a();
        a_m_tready = 1'b1;
        for (int i = 0; i < 64 && qa.size() != 0; i++) tick();
        a_m_tready = 1'b0;
        chk("a_drained", 64'(qa.size()), 64'd0);
        chk("a_empty_valid", 64'(a_m_tvalid), 64'd0);
    endtask

    task automatic drain_b();
        b_m_tready = 1'b1;
        for (int i = 0; i < 64 && qb.size() != 0; i++) tick();
        b_m_tready = 1'b0;
        chk("b_drained", 64'(qb.size()), 64'd0);
        chk("b_empty_valid", 64'(b_m_tvalid), 64'd0);
    endtask

    initial begin
        // Reset: asserted asynchronously, released just after an edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_a_tready", 64'(a_s_tready), 64'd0);
        chk("rst_a_tvalid", 64'(a_m_tvalid), 64'd0);
        chk("rst_b_count", 64'(b_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_a_tready_before_edge", 64'(a_s_tready), 64'd0);
        tick();
        chk("rel_a_tready", 64'(a_s_tready), 64'd1);
        chk("rel_b_tready", 64'(b_s_tready), 64'd1);

        // Cut-through ordering and 1-cycle latency.
        send_a(32'h11, 1'b0);
        chk("a_latency_valid", 64'(a_m_tvalid), 64'd1);
        chk("a_latency_data", 64'(a_m_tdata), 64'h11);
        send_a(32'h22, 1'b0);
        send_a(32'h33, 1'b0);
        a_s_tvalid = 1'b0;
        chk("a_count3", 64'(a_count), 64'd3);
        drain_a();

        // Full: no write while full; a read frees a slot for the next cycle.
        for (int i = 0; i < 4; i++) send_a(32'hA0 + 32'(i), 1'b0);
        a_s_tvalid = 1'b1; a_s_tdata = 32'hA4; a_s_tlast = 1'b0;
        chk("a_full_count", 64'(a_count), 64'd4);
        chk("a_full_tready", 64'(a_s_tready), 64'd0);
        a_m_tready = 1'b1;
        tick();
        a_m_tready = 1'b0;
        chk("a_freed_tready", 64'(a_s_tready), 64'd1);
        tick();
        a_s_tvalid = 1'b0;
        chk("a_refull_count", 64'(a_count), 64'd4);
        chk("a_refull_tready", 64'(a_s_tready), 64'd0);
        drain_a();
        chk("a_no_proto_err", 64'(a_proto_err), 64'd0);

        // Packet mode: output held until the TLAST beat is stored.
        b_m_tready = 1'b1;
        send_b(32'h31, 1'b0);
        chk("b_gate1", 64'(b_m_tvalid), 64'd0);
        send_b(32'h32, 1'b0);
        chk("b_gate2", 64'(b_m_tvalid), 64'd0);
        send_b(32'h33, 1'b1);
        b_s_tvalid = 1'b0;
        chk("b_release", 64'(b_m_tvalid), 64'd1);
        chk("b_pkt_count1", 64'(b_pkt_count), 64'd1);
        drain_b();
        chk("b_pkt_count0", 64'(b_pkt_count), 64'd0);
        chk("b_oversize_clear", 64'(b_oversize), 64'd0);

        // Oversize packet: full with no TLAST forces cut-through.
        for (int i = 0; i < 4; i++) send_b(32'h40 + 32'(i), 1'b0);
        b_s_tvalid = 1'b1; b_s_tdata = 32'h44; b_s_tlast = 1'b0;
        chk("b_over_count", 64'(b_count), 64'd4);
        chk("b_over_pkt", 64'(b_pkt_count), 64'd0);
        tick();
        chk("b_oversize", 64'(b_oversize), 64'd1);
        chk("b_forced_valid", 64'(b_m_tvalid), 64'd1);
        b_m_tready = 1'b1;
        send_b(32'h44, 1'b0);
        send_b(32'h45, 1'b1);
        b_s_tvalid = 1'b0;
        drain_b();
        chk("b_oversize_sticky", 64'(b_oversize), 64'd1);

        // Wraparound stream with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send_a(32'(i), 1'(i % 5 == 4));
        a_s_tvalid = 1'b0;
        rand_rdy = 1'b0;
        drain_a();
        chk("a_oversize_ct", 64'(a_oversize), 64'd0);
        chk("a_pkt_count_end", 64'(a_pkt_count), 64'd0);

        // Protocol checker: drop valid on a stalled beat.
        send_a(32'h60, 1'b0);
        send_a(32'h61, 1'b1);
        send_a(32'h62, 1'b0);
        send_a(32'h63, 1'b0);
        a_s_tvalid = 1'b1; a_s_tdata = 32'h64; a_s_tlast = 1'b0;
        tick();
        chk("a_stall_no_err", 64'(a_proto_err), 64'd0);
        a_s_tvalid = 1'b0;
        tick();
        chk("a_proto_err", 64'(a_proto_err), 64'd1);
        chk("a_pkt_count_full", 64'(a_pkt_count), 64'd1);
        chk("b_proto_clean", 64'(b_proto_err), 64'd0);

        // Reset mid-packet discards everything immediately.
        send_b(32'h70, 1'b0);
        send_b(32'h71, 1'b0);
        b_s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        qa.delete();
        qb.delete();
        chk("mid_rst_a_count", 64'(a_count), 64'd0);
        chk("mid_rst_a_pkt", 64'(a_pkt_count), 64'd0);
        chk("mid_rst_a_valid", 64'(a_m_tvalid), 64'd0);
        chk("mid_rst_a_proto", 64'(a_proto_err), 64'd0);
        chk("mid_rst_a_tready", 64'(a_s_tready), 64'd0);
        chk("mid_rst_b_count", 64'(b_count), 64'd0);
        chk("mid_rst_b_oversize", 64'(b_oversize), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_tready", 64'(a_s_tready), 64'd1);
        send_a(32'h77, 1'b1);
        a_s_tvalid = 1'b0;
        drain_a();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
